// File: rtl/aurora_pkg.sv
// Shared constants and types for the Aurora LocalLink frame checker and its
// matching pattern generator.
package aurora_pkg;

  localparam int          NLANE      = 3;
  localparam logic [15:0] HDR_MARKER = 16'hA55A;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_FRAMING = 3'd1,
    ERR_HDR     = 3'd2,
    ERR_LEN     = 3'd3,
    ERR_SEQ     = 3'd4,
    ERR_DATA    = 3'd5
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

endpackage

// File: rtl/aurora_frame_checker_if.sv
// LocalLink receive bundle: data, remainder and active-low framing/valid strobes.
interface aurora_frame_checker_if #(
  parameter int NLANE = aurora_pkg::NLANE
);
  localparam int DW = 16 * NLANE;

  logic [DW-1:0] rx_d;
  logic [2:0]    rx_rem;
  logic          rx_sof_n;
  logic          rx_eof_n;
  logic          rx_src_rdy_n;

  modport master (
    output rx_d, rx_rem, rx_sof_n, rx_eof_n, rx_src_rdy_n
  );

  modport slave (
    input rx_d, rx_rem, rx_sof_n, rx_eof_n, rx_src_rdy_n
  );
endinterface

// File: rtl/aurora_pattern_word.sv
// Expected payload word k of a frame starting at seq: (seq+k) mod 2^16 on every lane.
module aurora_pattern_word #(
  parameter int NLANE = aurora_pkg::NLANE
) (
  input  logic [15:0]         seq_i,
  input  logic [15:0]         k_i,
  output logic [16*NLANE-1:0] word_o
);
  logic [15:0] lane;

  assign lane   = seq_i + k_i;
  assign word_o = {NLANE{lane}};
endmodule

// File: rtl/aurora_frame_checker.sv
// Checks Aurora LocalLink frames (header, length, sequence, payload pattern) and
// reports good frames, classified errors, counters and a link-health LED.
module aurora_frame_checker #(
  parameter int NLANE  = aurora_pkg::NLANE,
  parameter int MAXLEN = 1023
) (
  input  logic                         clk,
  input  logic                         sys_rst,
  input  logic                         channel_up,
  aurora_frame_checker_if.slave        ll,
  output logic                         frame_good,
  output logic                         err,
  output logic [2:0]                   err_code,
  output logic [31:0]                  good_cnt,
  output logic [15:0]                  err_cnt,
  output logic                         locked,
  output logic                         led
);
  import aurora_pkg::*;

  localparam int          DW       = 16 * NLANE;
  localparam logic [2:0]  REM_FULL = 3'(2 * NLANE - 1);
  localparam logic [15:0] MAXLEN_L = 16'(MAXLEN);

  state_e      state_q, state_d;
  logic [15:0] k_q, k_d;
  logic [15:0] len_q, len_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] exp_seq_q, exp_seq_d;
  logic        bad_q, bad_d;
  logic        locked_q, locked_d;
  logic        led_q, led_d;
  logic [19:0] quiet_q, quiet_d;
  logic        good_q, good_d;
  logic        err_q, err_d;
  err_code_e   code_q, code_d;
  logic [31:0] good_cnt_q, good_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic          beat, sof, eof, rem_full;
  logic [15:0]   hdr_seq, hdr_len, hdr_marker;
  logic          hdr_ok, seq_err, data_err;
  logic [DW-1:0] exp_word;

  assign beat       = channel_up && !ll.rx_src_rdy_n;
  assign sof        = !ll.rx_sof_n;
  assign eof        = !ll.rx_eof_n;
  assign rem_full   = (ll.rx_rem == REM_FULL);
  assign hdr_seq    = ll.rx_d[DW-1  -: 16];
  assign hdr_len    = ll.rx_d[DW-17 -: 16];
  assign hdr_marker = ll.rx_d[DW-33 -: 16];
  assign hdr_ok     = (hdr_marker == HDR_MARKER) && (hdr_len != 16'd0) && (hdr_len <= MAXLEN_L);
  assign seq_err    = locked_q && (hdr_seq != exp_seq_q);
  assign data_err   = (ll.rx_d != exp_word);

  aurora_pattern_word #(.NLANE(NLANE)) u_pattern (
    .seq_i  (seq_q),
    .k_i    (k_q),
    .word_o (exp_word)
  );

  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    state_d   = state_q;
    k_d       = k_q;
    len_d     = len_q;
    seq_d     = seq_q;
    exp_seq_d = exp_seq_q;
    bad_d     = bad_q;
    locked_d  = locked_q;
    good_d    = 1'b0;
    code_d    = ERR_NONE;

    if (!channel_up) begin
      state_d  = ST_IDLE;
      k_d      = 16'd0;
      locked_d = 1'b0;
    end else if (beat && sof) begin
      // One code per beat: the ordering of these branches is the error priority.
      if (state_q != ST_IDLE) code_d = ERR_FRAMING;
      else if (!hdr_ok)       code_d = ERR_HDR;
      else if (eof)           code_d = ERR_LEN;
      else if (seq_err)       code_d = ERR_SEQ;

      if (hdr_ok) exp_seq_d = hdr_seq + 16'd1;

      if (!hdr_ok && !eof) begin
        state_d = ST_DISCARD;
        k_d     = 16'd0;
      end else if (!hdr_ok || eof) begin
        state_d = ST_IDLE;
        k_d     = 16'd0;
      end else begin
        state_d = ST_PAYLOAD;
        k_d     = 16'd1;
        len_d   = hdr_len;
        seq_d   = hdr_seq;
        bad_d   = seq_err;
      end
    end else if (beat) begin
      unique case (state_q)
        ST_IDLE: code_d = ERR_FRAMING;
        ST_PAYLOAD: begin
          if (eof) begin
            state_d = ST_IDLE;
            k_d     = 16'd0;
            if (k_q != len_q || !rem_full) code_d = ERR_LEN;
            else if (data_err)             code_d = ERR_DATA;
            else                           good_d = !bad_q;
          end else if (k_q == len_q) begin
            state_d = ST_DISCARD;
            k_d     = 16'd0;
            code_d  = ERR_LEN;
          end else begin
            k_d = k_q + 16'd1;
            if (data_err) begin
              code_d = ERR_DATA;
              bad_d  = 1'b1;
            end
          end
        end
        ST_DISCARD: begin
          if (eof) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (good_d) locked_d = 1'b1;

    err_d      = (code_d != ERR_NONE);
    good_cnt_d = good_d ? good_cnt_q + 32'd1 : good_cnt_q;
    err_cnt_d  = (err_d && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;

    // Cycles since the last error, saturating once a full 2^20 window is clean.
    if (err_d)                quiet_d = 20'd0;
    else if (quiet_q == '1)   quiet_d = quiet_q;
    else                      quiet_d = quiet_q + 20'd1;
    led_d = locked_d && (quiet_d == '1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      k_q        <= 16'd0;
      len_q      <= 16'd0;
      seq_q      <= 16'd0;
      exp_seq_q  <= 16'd0;
      bad_q      <= 1'b0;
      locked_q   <= 1'b0;
      led_q      <= 1'b0;
      quiet_q    <= '1;
      good_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      good_cnt_q <= 32'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      seq_q      <= seq_d;
      exp_seq_q  <= exp_seq_d;
      bad_q      <= bad_d;
      locked_q   <= locked_d;
      led_q      <= led_d;
      quiet_q    <= quiet_d;
      good_q     <= good_d;
      err_q      <= err_d;
      code_q     <= code_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign frame_good = good_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign good_cnt   = good_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign locked     = locked_q;
  assign led        = led_q;
endmodule

// File: tb/tb_aurora_frame_checker.sv
// Directed bench for aurora_frame_checker: good frames, every error class,
// length/header boundaries, channel drop, mid-frame reset and counter saturation.
module tb_aurora_frame_checker;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        channel_up;
  logic        frame_good, err;
  logic [2:0]  err_code;
  logic [31:0] good_cnt;
  logic [15:0] err_cnt;
  logic        locked, led;

  int tests = 0;
  int fails = 0;

  aurora_frame_checker_if #(.NLANE(3)) ll ();

  aurora_frame_checker #(.NLANE(3), .MAXLEN(1023)) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .channel_up (channel_up),
    .ll         (ll),
    .frame_good (frame_good),
    .err        (err),
    .err_code   (err_code),
    .good_cnt   (good_cnt),
    .err_cnt    (err_cnt),
    .locked     (locked),
    .led        (led)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] hdr(input logic [15:0] seq, input logic [15:0] len);
    return {seq, len, 16'hA55A};
  endfunction

  function automatic logic [47:0] pw(input logic [15:0] seq, input logic [15:0] k);
    logic [15:0] v;
    v = seq + k;
    return {v, v, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [47:0] d, input logic sof, input logic eof,
                      input logic [2:0] rem = 3'd5);
    ll.rx_d         = d;
    ll.rx_rem       = rem;
    ll.rx_sof_n     = !sof;
    ll.rx_eof_n     = !eof;
    ll.rx_src_rdy_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ll.rx_src_rdy_n = 1'b1;
    ll.rx_sof_n     = 1'b1;
    ll.rx_eof_n     = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic payload(input logic [15:0] seq, input int len);
    for (int k = 1; k <= len; k++) beat(pw(seq, 16'(k)), 1'b0, k == len);
  endtask

  task automatic pulse_reset();
    sys_rst         = 1'b1;
    ll.rx_src_rdy_n = 1'b1;
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
  endtask

  initial begin
    sys_rst         = 1'b1;
    channel_up      = 1'b1;
    ll.rx_d         = '0;
    ll.rx_rem       = 3'd5;
    ll.rx_sof_n     = 1'b1;
    ll.rx_eof_n     = 1'b1;
    ll.rx_src_rdy_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame_good", frame_good, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_good_cnt", good_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_locked", locked, 0);
    check("rst_led", led, 0);
    sys_rst = 1'b0;

    // Good frame seq 0x10 len 4.
    beat(hdr(16'h0010, 16'd4), 1'b1, 1'b0);
    check("good_hdr_err", err, 0);
    payload(16'h0010, 4);
    check("good_pulse", frame_good, 1);
    check("good_err", err, 0);
    check("good_cnt1", good_cnt, 1);
    check("good_locked", locked, 1);
    check("good_led", led, 1);
    idle(1);
    check("good_pulse_1cyc", frame_good, 0);

    // Locked, seq 0x20 where 0x11 is expected, then 0x21 is in sequence.
    beat(hdr(16'h0020, 16'd4), 1'b1, 1'b0);
    check("seq_err", err, 1);
    check("seq_code", err_code, 4);
    check("seq_err_cnt", err_cnt, 1);
    check("seq_led_off", led, 0);
    payload(16'h0020, 4);
    check("seq_no_good", frame_good, 0);
    check("seq_eof_err", err, 0);
    beat(hdr(16'h0021, 16'd4), 1'b1, 1'b0);
    check("seq_next_hdr_err", err, 0);
    payload(16'h0021, 4);
    check("seq_next_good", frame_good, 1);
    check("seq_next_cnt", good_cnt, 2);

    // Word 2 of seq 0x10 carries 0x0013 instead of 0x0012.
    pulse_reset();
    check("rst2_locked", locked, 0);
    check("rst2_good_cnt", good_cnt, 0);
    beat(hdr(16'h0010, 16'd4), 1'b1, 1'b0);
    beat(pw(16'h0010, 16'd1), 1'b0, 1'b0);
    beat({3{16'h0013}}, 1'b0, 1'b0);
    check("data_err", err, 1);
    check("data_code", err_code, 5);
    check("data_err_cnt", err_cnt, 1);
    beat(pw(16'h0010, 16'd3), 1'b0, 1'b0);
    check("data_continue", err, 0);
    beat(pw(16'h0010, 16'd4), 1'b0, 1'b1);
    check("data_no_good", frame_good, 0);
    check("data_eof_err", err, 0);
    beat(hdr(16'h0011, 16'd4), 1'b1, 1'b0);
    check("data_idle_after", err, 0);
    payload(16'h0011, 4);
    check("data_next_good", frame_good, 1);

    // Early EOF, then SOF+EOF on one beat, then a stray beat in IDLE.
    pulse_reset();
    beat(hdr(16'h0012, 16'd4), 1'b1, 1'b0);
    beat(pw(16'h0012, 16'd1), 1'b0, 1'b0);
    beat(pw(16'h0012, 16'd2), 1'b0, 1'b0);
    beat(pw(16'h0012, 16'd3), 1'b0, 1'b1);
    check("short_code", err_code, 3);
    check("short_err", err, 1);
    check("short_no_good", frame_good, 0);
    beat(hdr(16'h0013, 16'd4), 1'b1, 1'b1);
    check("sofeof_code", err_code, 3);
    check("sofeof_err_cnt", err_cnt, 2);
    beat(pw(16'h0000, 16'd1), 1'b0, 1'b0);
    check("idle_framing_code", err_code, 1);
    check("idle_framing_cnt", err_cnt, 3);

    // len=1 is the shortest legal frame.
    beat(hdr(16'h0100, 16'd1), 1'b1, 1'b0);
    check("len1_hdr_err", err, 0);
    beat(pw(16'h0100, 16'd1), 1'b0, 1'b1);
    check("len1_good", frame_good, 1);
    check("len1_locked", locked, 1);

    // len = MAXLEN+1, len = 0, bad marker: header errors, silent discard.
    beat(hdr(16'h0101, 16'd1024), 1'b1, 1'b0);
    check("len_big_code", err_code, 2);
    beat(pw(16'h0101, 16'd1), 1'b0, 1'b0);
    check("discard_quiet", err, 0);
    beat(48'h0, 1'b0, 1'b1);
    check("discard_eof_quiet", err, 0);
    beat(hdr(16'h0101, 16'd0), 1'b1, 1'b0);
    check("len0_code", err_code, 2);
    beat(48'h0, 1'b0, 1'b1);
    beat({16'h0101, 16'd4, 16'hA55B}, 1'b1, 1'b0);
    check("marker_code", err_code, 2);
    check("marker_err_cnt", err_cnt, 6);
    beat(48'h0, 1'b0, 1'b1);

    // SOF inside a payload: framing error, new header still taken.
    beat(hdr(16'h0101, 16'd4), 1'b1, 1'b0);
    check("resync_hdr_err", err, 0);
    beat(pw(16'h0101, 16'd1), 1'b0, 1'b0);
    beat(hdr(16'h0102, 16'd2), 1'b1, 1'b0);
    check("resync_code", err_code, 1);
    payload(16'h0102, 2);
    check("resync_good", frame_good, 1);
    check("resync_good_cnt", good_cnt, 2);

    // EOF at k=len with a partial remainder.
    beat(hdr(16'h0103, 16'd2), 1'b1, 1'b0);
    beat(pw(16'h0103, 16'd1), 1'b0, 1'b0);
    beat(pw(16'h0103, 16'd2), 1'b0, 1'b1, 3'd3);
    check("rem_code", err_code, 3);
    check("rem_no_good", frame_good, 0);

    // No EOF at k=len: overrun goes to DISCARD until EOF.
    beat(hdr(16'h0104, 16'd2), 1'b1, 1'b0);
    beat(pw(16'h0104, 16'd1), 1'b0, 1'b0);
    beat(pw(16'h0104, 16'd2), 1'b0, 1'b0);
    check("overrun_code", err_code, 3);
    check("overrun_err_cnt", err_cnt, 9);
    beat(pw(16'h0104, 16'd3), 1'b0, 1'b0);
    check("overrun_discard", err, 0);
    beat(48'h0, 1'b0, 1'b1);
    beat(hdr(16'h0105, 16'd1), 1'b1, 1'b0);
    check("overrun_idle_after", err, 0);
    beat(pw(16'h0105, 16'd1), 1'b0, 1'b1);
    check("overrun_next_good", frame_good, 1);

    // len = MAXLEN is accepted.
    beat(hdr(16'h0106, 16'd1023), 1'b1, 1'b0);
    check("maxlen_hdr_err", err, 0);
    payload(16'h0106, 1023);
    check("maxlen_good", frame_good, 1);
    check("maxlen_good_cnt", good_cnt, 4);
    check("led_recent_err", led, 0);

    // Channel drop mid-frame.
    beat(hdr(16'h0107, 16'd4), 1'b1, 1'b0);
    beat(pw(16'h0107, 16'd1), 1'b0, 1'b0);
    channel_up = 1'b0;
    idle(1);
    check("chdown_err", err, 0);
    check("chdown_locked", locked, 0);
    check("chdown_led", led, 0);
    check("chdown_good_cnt", good_cnt, 4);
    check("chdown_err_cnt", err_cnt, 9);
    channel_up = 1'b1;
    beat(hdr(16'h0300, 16'd4), 1'b1, 1'b0);
    check("chup_hdr_err", err, 0);
    payload(16'h0300, 4);
    check("chup_good", frame_good, 1);
    check("chup_locked", locked, 1);

    // Reset asserted on word 2 of a frame.
    beat(hdr(16'h0301, 16'd4), 1'b1, 1'b0);
    beat(pw(16'h0301, 16'd1), 1'b0, 1'b0);
    sys_rst = 1'b1;
    beat(pw(16'h0301, 16'd2), 1'b0, 1'b0);
    sys_rst = 1'b0;
    check("midrst_err", err, 0);
    check("midrst_locked", locked, 0);
    check("midrst_err_cnt", err_cnt, 0);
    beat(hdr(16'h0500, 16'd4), 1'b1, 1'b0);
    check("midrst_hdr_err", err, 0);
    payload(16'h0500, 4);
    check("midrst_good", frame_good, 1);
    check("midrst_good_cnt", good_cnt, 1);
    check("midrst_led", led, 1);

    // Stray beats in IDLE until err_cnt saturates.
    beat(pw(16'h0000, 16'd1), 1'b0, 1'b0);
    check("sat_first_code", err_code, 1);
    check("sat_first_cnt", err_cnt, 1);
    ll.rx_src_rdy_n = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("sat_err_cnt", err_cnt, 16'hFFFF);
    check("sat_err", err, 1);
    check("sat_code", err_code, 1);
    check("sat_good_hold", good_cnt, 1);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
